// File: rtl/vending_machine_multi.sv
// Multi-product vending controller: coin credit, stock tracking, dispense and change; optional AUTO_REFUND_EN idle timeout.
// Registered outputs; a vend completes in 3 cycles after selection; no backpressure, so unacceptable coins are pulsed back via coin_reject.
module vending_machine_multi #(
  parameter int MONEY_W        = 8,
  parameter int NUM_DRINKS     = 4,
  parameter int SEL_W          = 3,
  parameter logic [NUM_DRINKS*MONEY_W-1:0] PRICES = {8'd25, 8'd20, 8'd15, 8'd10},
  parameter int STOCK_W        = 4,
  parameter int INIT_STOCK     = 5,
  parameter int MAX_CREDIT     = 200,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [MONEY_W-1:0]    coin,
  input  logic [SEL_W-1:0]      drink_choose,
  input  logic                  cancel,
  input  logic                  restock_valid,
  input  logic [SEL_W-1:0]      restock_id,
  input  logic [STOCK_W-1:0]    restock_qty,
  output logic [MONEY_W-1:0]    total_money,
  output logic [2:0]            state,
  output logic [SEL_W-1:0]      drink_out,
  output logic                  drink_valid,
  output logic [MONEY_W-1:0]    exchange,
  output logic                  exchange_valid,
  output logic                  coin_reject,
  output logic [NUM_DRINKS-1:0] sold_out
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CREDIT = 3'd1;
  localparam logic [2:0] S_VEND   = 3'd2;
  localparam logic [2:0] S_CHANGE = 3'd3;
  localparam logic [2:0] S_REFUND = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [MONEY_W-1:0] total_q, total_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [MONEY_W-1:0] price_q, price_d;
  logic [SEL_W-1:0]   drink_out_q, drink_out_d;
  logic               drink_valid_q, drink_valid_d;
  logic [MONEY_W-1:0] exchange_q, exchange_d;
  logic               exchange_valid_q, exchange_valid_d;
  logic               coin_reject_q, coin_reject_d;
  logic [STOCK_W-1:0] stock_q [NUM_DRINKS];
  logic [STOCK_W-1:0] stock_d [NUM_DRINKS];

  logic [MONEY_W:0]   coin_sum;
  logic               coin_ok;
  logic               sel_hit;
  logic               sel_stock_ok;
  logic [MONEY_W-1:0] sel_price;
  logic               vend_dec;
  logic               timeout_hit;

  // Sum one bit wider than the credit so the ceiling test cannot wrap.
  assign coin_sum = {1'b0, total_q} + {1'b0, coin};
  assign coin_ok  = ((coin == MONEY_W'(1)) || (coin == MONEY_W'(5)) ||
                     (coin == MONEY_W'(10)) || (coin == MONEY_W'(50))) &&
                    (coin_sum <= (MONEY_W+1)'(MAX_CREDIT));

  always_comb begin
    sel_hit      = 1'b0;
    sel_stock_ok = 1'b0;
    sel_price    = '0;
    for (int i = 0; i < NUM_DRINKS; i++) begin
      if (drink_choose == SEL_W'(i + 1)) begin
        sel_hit      = 1'b1;
        sel_stock_ok = (stock_q[i] != '0);
        sel_price    = PRICES[i*MONEY_W +: MONEY_W];
      end
    end
  end

`ifdef AUTO_REFUND_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0] idle_cnt_q, idle_cnt_d;
  logic             inactive;

  assign inactive    = (coin == '0) && (drink_choose == '0) && !cancel;
  assign timeout_hit = (state_q == S_CREDIT) && inactive &&
                       (idle_cnt_q == TMR_W'(TIMEOUT_CYCLES - 1));
  assign idle_cnt_d  = ((state_q == S_CREDIT) && inactive && !timeout_hit) ?
                       idle_cnt_q + TMR_W'(1) : '0;

  always_ff @(posedge clk) begin
    if (reset) idle_cnt_q <= '0;
    else       idle_cnt_q <= idle_cnt_d;
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d          = state_q;
    total_d          = total_q;
    sel_d            = sel_q;
    price_d          = price_q;
    drink_out_d      = '0;
    drink_valid_d    = 1'b0;
    exchange_d       = '0;
    exchange_valid_d = 1'b0;
    coin_reject_d    = (coin != '0);
    vend_dec         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (coin_ok) begin
          total_d       = coin_sum[MONEY_W-1:0];
          coin_reject_d = 1'b0;
          state_d       = S_CREDIT;
        end
      end
      S_CREDIT: begin
        if (cancel) begin
          state_d = S_REFUND;
        end else if (coin_ok) begin
          total_d       = coin_sum[MONEY_W-1:0];
          coin_reject_d = 1'b0;
        end else if (sel_hit && sel_stock_ok && (total_q >= sel_price)) begin
          sel_d   = drink_choose;
          price_d = sel_price;
          state_d = S_VEND;
        end else if (timeout_hit) begin
          state_d = S_REFUND;
        end
      end
      S_VEND: begin
        drink_out_d   = sel_q;
        drink_valid_d = 1'b1;
        vend_dec      = 1'b1;
        state_d       = S_CHANGE;
      end
      S_CHANGE: begin
        exchange_d       = total_q - price_q;
        exchange_valid_d = 1'b1;
        total_d          = '0;
        sel_d            = '0;
        price_d          = '0;
        state_d          = S_IDLE;
      end
      S_REFUND: begin
        exchange_d       = total_q;
        exchange_valid_d = 1'b1;
        total_d          = '0;
        state_d          = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Restock and vend decrement merge into one saturating update per product.
  always_comb begin
    for (int i = 0; i < NUM_DRINKS; i++) begin
      logic [STOCK_W:0] sum_v;
      sum_v = {1'b0, stock_q[i]};
      if (restock_valid && (restock_id == SEL_W'(i + 1)))
        sum_v = sum_v + {1'b0, restock_qty};
      if (vend_dec && (sel_q == SEL_W'(i + 1)) && (sum_v != '0))
        sum_v = sum_v - (STOCK_W+1)'(1);
      if (sum_v > {1'b0, {STOCK_W{1'b1}}}) stock_d[i] = {STOCK_W{1'b1}};
      else                                 stock_d[i] = sum_v[STOCK_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_IDLE;
      total_q          <= '0;
      sel_q            <= '0;
      price_q          <= '0;
      drink_out_q      <= '0;
      drink_valid_q    <= 1'b0;
      exchange_q       <= '0;
      exchange_valid_q <= 1'b0;
      coin_reject_q    <= 1'b0;
      for (int i = 0; i < NUM_DRINKS; i++) stock_q[i] <= STOCK_W'(INIT_STOCK);
    end else begin
      state_q          <= state_d;
      total_q          <= total_d;
      sel_q            <= sel_d;
      price_q          <= price_d;
      drink_out_q      <= drink_out_d;
      drink_valid_q    <= drink_valid_d;
      exchange_q       <= exchange_d;
      exchange_valid_q <= exchange_valid_d;
      coin_reject_q    <= coin_reject_d;
      for (int i = 0; i < NUM_DRINKS; i++) stock_q[i] <= stock_d[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_DRINKS; i++) sold_out[i] = (stock_q[i] == '0);
  end

  assign total_money    = total_q;
  assign state          = state_q;
  assign drink_out      = drink_out_q;
  assign drink_valid    = drink_valid_q;
  assign exchange       = exchange_q;
  assign exchange_valid = exchange_valid_q;
  assign coin_reject    = coin_reject_q;

endmodule

// File: tb/tb_vending_machine_multi.sv
// Directed bench for vending_machine_multi: vector table plus sequences for stock, reset and timeout.
module tb_vending_machine_multi;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] coin;
  logic [2:0] drink_choose;
  logic       cancel;
  logic       restock_valid;
  logic [2:0] restock_id;
  logic [3:0] restock_qty;
  logic [7:0] total_money;
  logic [2:0] state;
  logic [2:0] drink_out;
  logic       drink_valid;
  logic [7:0] exchange;
  logic       exchange_valid;
  logic       coin_reject;
  logic [3:0] sold_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vending_machine_multi #(
    .MONEY_W(8), .NUM_DRINKS(4), .SEL_W(3),
    .PRICES({8'd25, 8'd20, 8'd15, 8'd10}),
    .STOCK_W(4), .INIT_STOCK(5), .MAX_CREDIT(200), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset), .coin(coin), .drink_choose(drink_choose),
    .cancel(cancel), .restock_valid(restock_valid), .restock_id(restock_id),
    .restock_qty(restock_qty), .total_money(total_money), .state(state),
    .drink_out(drink_out), .drink_valid(drink_valid), .exchange(exchange),
    .exchange_valid(exchange_valid), .coin_reject(coin_reject), .sold_out(sold_out)
  );

  typedef struct {
    int coin; int sel; int cncl;
    int total; int st; int dv; int dout; int ev; int exch; int rej;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs [NV];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Apply inputs for one clock edge, then sample 1 time unit after it.
  task automatic cyc(input int c, input int s, input int k);
    coin         = 8'(c);
    drink_choose = 3'(s);
    cancel       = k[0];
    @(posedge clk);
    #1;
    coin          = '0;
    drink_choose  = '0;
    cancel        = 1'b0;
    restock_valid = 1'b0;
  endtask

  task automatic vend_id1();
    cyc(10, 0, 0);
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
  endtask

  initial begin
    // coin sel cncl | total st dv dout ev exch rej
    vecs[0]  = '{10, 0, 0,  10, 1, 0, 0, 0, 0, 0};
    vecs[1]  = '{ 5, 0, 0,  15, 1, 0, 0, 0, 0, 0};
    vecs[2]  = '{10, 0, 0,  25, 1, 0, 0, 0, 0, 0};
    vecs[3]  = '{ 0, 3, 0,  25, 2, 0, 0, 0, 0, 0};
    vecs[4]  = '{ 0, 0, 0,  25, 3, 1, 3, 0, 0, 0};
    vecs[5]  = '{ 0, 0, 0,   0, 0, 0, 0, 1, 5, 0};
    vecs[6]  = '{ 7, 0, 0,   0, 0, 0, 0, 0, 0, 1};
    vecs[7]  = '{50, 0, 0,  50, 1, 0, 0, 0, 0, 0};
    vecs[8]  = '{50, 0, 0, 100, 1, 0, 0, 0, 0, 0};
    vecs[9]  = '{50, 0, 0, 150, 1, 0, 0, 0, 0, 0};
    vecs[10] = '{10, 0, 0, 160, 1, 0, 0, 0, 0, 0};
    vecs[11] = '{ 7, 0, 0, 160, 1, 0, 0, 0, 0, 1};
    vecs[12] = '{50, 0, 0, 160, 1, 0, 0, 0, 0, 1};
    vecs[13] = '{ 0, 0, 1, 160, 4, 0, 0, 0, 0, 0};
    vecs[14] = '{ 0, 0, 0,   0, 0, 0, 0, 1, 160, 0};
    vecs[15] = '{10, 0, 0,  10, 1, 0, 0, 0, 0, 0};
    vecs[16] = '{ 0, 4, 0,  10, 1, 0, 0, 0, 0, 0};
    vecs[17] = '{ 0, 7, 0,  10, 1, 0, 0, 0, 0, 0};
    vecs[18] = '{ 0, 0, 1,  10, 4, 0, 0, 0, 0, 0};
    vecs[19] = '{ 0, 0, 0,   0, 0, 0, 0, 1, 10, 0};
    vecs[20] = '{50, 0, 0,  50, 1, 0, 0, 0, 0, 0};
    vecs[21] = '{50, 0, 1,  50, 4, 0, 0, 0, 0, 1};
    vecs[22] = '{ 0, 0, 0,   0, 0, 0, 0, 1, 50, 0};
    vecs[23] = '{ 0, 1, 1,   0, 0, 0, 0, 0, 0, 0};
    vecs[24] = '{10, 0, 0,  10, 1, 0, 0, 0, 0, 0};
    vecs[25] = '{ 0, 1, 0,  10, 2, 0, 0, 0, 0, 0};
    vecs[26] = '{ 0, 0, 0,  10, 3, 1, 1, 0, 0, 0};
    vecs[27] = '{ 0, 0, 0,   0, 0, 0, 0, 1, 0, 0};

    reset = 1'b1; coin = '0; drink_choose = '0; cancel = 1'b0;
    restock_valid = 1'b0; restock_id = '0; restock_qty = '0;
    @(posedge clk); @(posedge clk); #1;
    chk("reset state", int'(state), 0);
    chk("reset total", int'(total_money), 0);
    chk("reset drink_valid", int'(drink_valid), 0);
    chk("reset exchange_valid", int'(exchange_valid), 0);
    chk("reset coin_reject", int'(coin_reject), 0);
    chk("reset sold_out", int'(sold_out), 0);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      cyc(vecs[i].coin, vecs[i].sel, vecs[i].cncl);
      chk($sformatf("vec%0d total", i), int'(total_money), vecs[i].total);
      chk($sformatf("vec%0d state", i), int'(state), vecs[i].st);
      chk($sformatf("vec%0d drink_valid", i), int'(drink_valid), vecs[i].dv);
      chk($sformatf("vec%0d drink_out", i), int'(drink_out), vecs[i].dout);
      chk($sformatf("vec%0d exchange_valid", i), int'(exchange_valid), vecs[i].ev);
      chk($sformatf("vec%0d exchange", i), int'(exchange), vecs[i].exch);
      chk($sformatf("vec%0d coin_reject", i), int'(coin_reject), vecs[i].rej);
      chk($sformatf("vec%0d sold_out", i), int'(sold_out), 0);
    end

    // id 1 has 4 left: drain it and confirm the sold-out flag and rejected select.
    for (int n = 0; n < 3; n++) vend_id1();
    chk("id1 not yet sold out", int'(sold_out), 0);
    vend_id1();
    chk("id1 sold out", int'(sold_out), 1);
    cyc(10, 0, 0);
    cyc(0, 1, 0);
    chk("sold-out select ignored", int'(state), 1);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    chk("sold-out refund", int'(exchange), 10);

    // Restock to 15, then +3 must saturate at 15: exactly 15 vends empty it.
    restock_valid = 1'b1; restock_id = 3'd1; restock_qty = 4'd15;
    cyc(0, 0, 0);
    chk("restock clears sold_out", int'(sold_out), 0);
    restock_valid = 1'b1; restock_id = 3'd1; restock_qty = 4'd3;
    cyc(0, 0, 0);
    restock_valid = 1'b1; restock_id = 3'd0; restock_qty = 4'd15;
    cyc(0, 0, 0);
    for (int n = 0; n < 14; n++) vend_id1();
    chk("saturated stock after 14 vends", int'(sold_out), 0);
    vend_id1();
    chk("saturated stock after 15 vends", int'(sold_out), 1);

    // Reset in the middle of a vend, with a coin present, wins over everything.
    cyc(10, 0, 0);
    cyc(5, 0, 0);
    cyc(0, 2, 0);
    chk("vend id2 state", int'(state), 2);
    reset = 1'b1;
    cyc(50, 0, 0);
    reset = 1'b0;
    chk("mid-vend reset state", int'(state), 0);
    chk("mid-vend reset total", int'(total_money), 0);
    chk("mid-vend reset drink_valid", int'(drink_valid), 0);
    chk("mid-vend reset drink_out", int'(drink_out), 0);
    chk("mid-vend reset exchange_valid", int'(exchange_valid), 0);
    chk("mid-vend reset coin_reject", int'(coin_reject), 0);
    chk("mid-vend reset stock", int'(sold_out), 0);

    cyc(10, 0, 0);
    cyc(5, 0, 0);
`ifdef AUTO_REFUND_EN
    for (int n = 0; n < 7; n++) cyc(0, 0, 0);
    chk("timeout still credit", int'(state), 1);
    cyc(0, 0, 0);
    chk("timeout refund state", int'(state), 4);
    cyc(0, 0, 0);
    chk("timeout exchange_valid", int'(exchange_valid), 1);
    chk("timeout exchange", int'(exchange), 15);
    chk("timeout idle", int'(state), 0);
`else
    for (int n = 0; n < 100; n++) cyc(0, 0, 0);
    chk("credit held state", int'(state), 1);
    chk("credit held total", int'(total_money), 15);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    chk("credit held refund", int'(exchange), 15);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vending_machine_multi.md
Name: vending_machine_multi

Overview:
Parametrised successor to the single-product vending controller.
- Configurable product count, price table, money width and credit ceiling.
- Per-product stock counters with restock port; sold-out flags.
- Coin validation and rejection; coins accepted while a credit balance exists; cancel/refund path.
- Sits between the coin acceptor/keypad front end and the dispense/change mechanics.

Parameters:
- MONEY_W, 8: width of coin, credit and change values.
- NUM_DRINKS, 4: number of products; product ids 1..NUM_DRINKS, id 0 = none.
- SEL_W, 3: width of product id buses; must satisfy 2^SEL_W > NUM_DRINKS.
- PRICES, {8'd25,8'd20,8'd15,8'd10}: packed price table; price of id i at bits [(i-1)*MONEY_W +: MONEY_W].
- STOCK_W, 4: width of each stock counter; counter saturates at 2^STOCK_W-1.
- INIT_STOCK, 5: every stock counter loads this value on reset.
- MAX_CREDIT, 200: upper limit on accumulated credit.
- TIMEOUT_CYCLES, 1000: idle-credit timeout; used only with AUTO_REFUND_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- coin  in  MONEY_W  coin value this cycle; 0 = no coin.
- drink_choose  in  SEL_W  product selection; 0 = none.
- cancel  in  1  refund request.
- restock_valid  in  1  restock strobe.
- restock_id  in  SEL_W  product to restock.
- restock_qty  in  STOCK_W  units to add.
- total_money  out  MONEY_W  current credit (registered).
- state  out  3  FSM state code.
- drink_out  out  SEL_W  dispensed id; non-zero only while drink_valid=1.
- drink_valid  out  1  one-cycle dispense pulse.
- exchange  out  MONEY_W  change/refund value; non-zero only while exchange_valid=1.
- exchange_valid  out  1  one-cycle change pulse.
- coin_reject  out  1  one-cycle pulse: last coin returned, not credited.
- sold_out  out  NUM_DRINKS  bit i-1 = stock of id i is 0; combinational from stock registers.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, sampled on the posedge of clk; it takes priority over all other inputs in any state, including mid-vend.
- Reset values: state=IDLE, total_money=0, drink_out=0, drink_valid=0, exchange=0, exchange_valid=0, coin_reject=0, all stock=INIT_STOCK, internal latches cleared.
- State codes: IDLE=0, CREDIT=1, VEND=2, CHANGE=3, REFUND=4. Unused codes return to IDLE next cycle.
- Outputs are registered. drink_valid, exchange_valid and coin_reject are high for exactly one cycle; drink_out and exchange are 0 whenever their valid is 0.
- Coin acceptance:
  - A coin is accepted only in IDLE or CREDIT, and only if its value is one of 1, 5, 10, 50 and total_money+coin <= MAX_CREDIT. Compare at MONEY_W+1 bits so there is no wrap.
  - Accepted coin: total_money += coin in the next cycle.
  - Any other non-zero coin: credit unchanged and coin_reject=1 in the next cycle. This includes any coin arriving in VEND, CHANGE or REFUND.
- IDLE:
  - An accepted coin moves to CREDIT.
  - cancel and drink_choose are ignored.
- CREDIT, input priority per cycle is cancel > coin > selection:
  - cancel -> REFUND. A coin in the same cycle is rejected.
  - Accepted coin -> stay in CREDIT; any selection in the same cycle is ignored.
  - Selection: drink_choose in 1..NUM_DRINKS with total_money >= price and stock > 0 -> latch id and price, go to VEND.
  - Out-of-range id, insufficient credit or sold-out product -> ignored, stay in CREDIT.
- VEND (1 cycle): set drink_out=id and drink_valid=1 (visible in the next cycle), decrement stock[id], go to CHANGE.
- CHANGE (1 cycle): set exchange=total_money-price and exchange_valid=1, even when the difference is 0. Set total_money=0, clear latches, go to IDLE.
- REFUND (1 cycle): set exchange=total_money and exchange_valid=1, total_money=0, go to IDLE.
- Latency:
  - Selection accepted at posedge n: state=VEND after n, drink_valid after n+1, exchange_valid and state=IDLE after n+2.
  - Cancel accepted at posedge n: exchange_valid and state=IDLE after n+1.
- Restock:
  - Accepted in any state: stock[restock_id] += restock_qty, saturating at 2^STOCK_W-1.
  - restock_id of 0 or > NUM_DRINKS is ignored.
  - Restock and VEND decrement on the same id in the same cycle: net result is stock + qty - 1, saturating.

Optional Feature:
AUTO_REFUND_EN
- Defined: an inactivity counter runs while in CREDIT and clears on any non-zero coin, non-zero drink_choose or cancel. Once TIMEOUT_CYCLES consecutive inactive cycles have elapsed, the FSM enters REFUND and behaves exactly as a cancel would. The counter also clears on leaving CREDIT.
- Not defined: no counter is built; credit is held indefinitely. TIMEOUT_CYCLES is unused.

Test Plan:
- Coins 10, 5, 10 in consecutive cycles, then drink_choose=3 -> total_money=25; drink_valid with drink_out=3; exchange=5 with exchange_valid; total_money=0; stock[3]=4.
- Coin 7, then coin 50 with total 160 (MAX_CREDIT=200) -> coin_reject pulse for each; total_money stays 160.
- Credit 10, drink_choose=4 -> ignored, state=CREDIT. Then cancel -> state=REFUND, exchange=10 pulse, state=IDLE, stock unchanged.
- Vend id 1 five times from INIT_STOCK=5 -> sold_out[0]=1; sixth select rejected. Then restock_id=1, qty=15 with stock 0 -> stock=15; then qty=3 -> saturates at 15.
- Coin 50 and cancel in the same CREDIT cycle -> refund of the prior credit only, coin_reject=1. reset asserted during VEND -> all outputs 0 next cycle, stock=INIT_STOCK.
- AUTO_REFUND_EN with TIMEOUT_CYCLES=8: credit 15, then idle 8 cycles -> exchange=15 pulse, state returns to IDLE. Without the macro -> still CREDIT with total_money=15 after 100 cycles.
